// File: rtl/csa_pkg.sv
// ---------------------------------------------------------------------------
// csa_pkg
// Shared definitions for the three-operand carry-save adder.
//   CSA_WIDTH : default operand width
//   operand_t : one unsigned operand
//   sum_t     : operand width plus one bit (the registered sum without cout)
// ---------------------------------------------------------------------------
package csa_pkg;

   localparam int CSA_WIDTH = 32;

   typedef logic [CSA_WIDTH-1:0] operand_t;
   typedef logic [CSA_WIDTH:0]   sum_t;

endpackage : csa_pkg

// File: rtl/full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
// One-bit full adder. It is used both as a 3:2 compressor cell in the
// carry-save row and as a ripple cell in the final carry-propagate adder.
//   x, y, z : input bits
//   sum     : x ^ y ^ z
//   carry   : majority(x, y, z)
// ---------------------------------------------------------------------------
module full_adder (
   input  logic x,
   input  logic y,
   input  logic z,
   output logic sum,
   output logic carry
);

   assign sum   = x ^ y ^ z;
   assign carry = (x & y) | (x & z) | (y & z);

endmodule : full_adder

// File: rtl/csa32.sv
// ---------------------------------------------------------------------------
// csa32
// Registered three-operand unsigned adder. A carry-save row compresses
// a, b and c into a partial sum and a partial carry. A ripple adder then
// resolves them into the exact (WIDTH+2)-bit result {cout, s} = a + b + c.
// The result is registered, so latency is one cycle and a new operand set
// is accepted on every clock.
//   clk   : rising-edge clock
//   rst_n : synchronous reset, ACTIVE-HIGH despite the name
//   a,b,c : unsigned operands, WIDTH bits each
//   s     : registered sum bits [WIDTH:0]
//   cout  : registered top carry, bit [WIDTH+1]
// ---------------------------------------------------------------------------
module csa32
   import csa_pkg::*;
#(
   parameter int WIDTH = CSA_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   output logic [WIDTH:0]   s,
   output logic             cout
);

   logic [WIDTH-1:0] ps;       // carry-save partial sum
   logic [WIDTH-1:0] pc;       // carry-save partial carry, weight 2^(i+1)
   logic [WIDTH:0]   s_d;
   logic             cout_d;
   logic [WIDTH+1:1] cy;       // cy[i] is the carry into result bit i
   logic [WIDTH:0]   s_q;
   logic             cout_q;

   // ---------------- carry-save (3:2) row ----------------
   for (genvar i = 0; i < WIDTH; i++) begin : g_csa
      full_adder u_fa (
         .x     (a[i]),
         .y     (b[i]),
         .z     (c[i]),
         .sum   (ps[i]),
         .carry (pc[i])
      );
   end

   // ---------------- final carry-propagate adder ----------------
   // Adds ps to (pc << 1). Bit 0 only has ps[0], so it needs no cell and
   // the chain starts at bit 1 with no carry in.
   assign s_d[0] = ps[0];
   assign cy[1]  = 1'b0;

   for (genvar i = 1; i <= WIDTH; i++) begin : g_cpa
      if (i < WIDTH) begin : g_mid
         full_adder u_fa (
            .x     (ps[i]),
            .y     (pc[i-1]),
            .z     (cy[i]),
            .sum   (s_d[i]),
            .carry (cy[i+1])
         );
      end else begin : g_top
         // ps has no bit WIDTH, so the top cell sees a zero there.
         full_adder u_fa (
            .x     (1'b0),
            .y     (pc[i-1]),
            .z     (cy[i]),
            .sum   (s_d[i]),
            .carry (cy[i+1])
         );
      end
   end

   assign cout_d = cy[WIDTH+1];

   // ---------------- output register ----------------
   // NOTE: sequential state uses non-blocking assignments so that every
   // register samples its inputs from before the edge, independent of
   // statement order.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         s_q    <= '0;
         cout_q <= 1'b0;
      end else begin
         s_q    <= s_d;
         cout_q <= cout_d;
      end
   end

   assign s    = s_q;
   assign cout = cout_q;

endmodule : csa32

// File: tb/tb_csa32.sv
// ---------------------------------------------------------------------------
// tb_csa32
// Directed and random stimulus for csa32. Expected results are hand-computed
// constants, or a + b + c evaluated at 34 bits.
// ---------------------------------------------------------------------------
module tb_csa32;
   import csa_pkg::*;

   logic     clk = 1'b0;
   logic     rst_n;
   operand_t a, b, c;
   sum_t     s;
   logic     cout;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   csa32 #(.WIDTH(CSA_WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a),
      .b     (b),
      .c     (c),
      .s     (s),
      .cout  (cout)
   );

   task automatic check(input string tag, input logic [33:0] got,
                        input logic [33:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive one operand set at the falling edge, then return just after the
   // rising edge that samples it.
   task automatic step(input logic r, input operand_t va, input operand_t vb,
                       input operand_t vc);
      @(negedge clk);
      rst_n = r;
      a     = va;
      b     = vb;
      c     = vc;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic        r;
      operand_t    va, vb, vc;
      logic [33:0] exp;

      rst_n = 1'b1;
      a = '0;
      b = '0;
      c = '0;

      // Reset with nonzero operands clears the outputs.
      step(1'b1, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333);
      check("reset", {cout, s}, 34'h0);

      // First edge after release shows the real sum.
      step(1'b0, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001);
      check("ones", {cout, s}, 34'h0_0000_0003);

      // Inputs changing between edges must not reach the outputs.
      @(negedge clk);
      a = 32'hFFFF_FFFF;
      b = 32'hFFFF_FFFF;
      #1;
      check("hold", {cout, s}, 34'h0_0000_0003);

      step(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001);
      check("carry_b32", {cout, s}, 34'h1_0000_0001);

      step(1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF);
      check("alt_bits", {cout, s}, 34'h1_FFFF_FFFE);

      step(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0FED_CBA9);
      check("mixed", {cout, s}, 34'h0_BCDF_0111);

      step(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("max", {cout, s}, 34'h2_FFFF_FFFD);
      check("max_cout", {33'h0, cout}, 34'h1);

      step(1'b0, 32'h0, 32'h0, 32'h0);
      check("zero", {cout, s}, 34'h0);

      // Back-to-back random operands with a two-cycle reset pulse mid-stream.
      for (int i = 0; i < 40; i++) begin
         r  = (i == 20) || (i == 21);
         va = $urandom();
         vb = $urandom();
         vc = $urandom();
         step(r, va, vb, vc);
         exp = r ? 34'h0 : ({2'b00, va} + {2'b00, vb} + {2'b00, vc});
         check($sformatf("rand%0d", i), {cout, s}, exp);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_csa32
